// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake and registered result/flags.
// Define ALU_PIPE_MUL_EN to enable the iterative shift-add multiplier (op 11).
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             car,
    output logic             of,
    output logic             zf,
    output logic             nf
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] alu_res;
    logic             alu_car;
    logic             alu_of;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SW-1:0]    sh;
    logic             accept;

    assign accept = in_valid && in_ready;

    // Single-cycle operations; carry and overflow stay 0 unless add/sub set them.
    always_comb begin
        alu_res = '0;
        alu_car = 1'b0;
        alu_of  = 1'b0;
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        sh      = b[SW-1:0];
        case (op)
            4'd0: begin
                alu_res = sum[WIDTH-1:0];
                alu_car = sum[WIDTH];
                alu_of  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                alu_res = diff[WIDTH-1:0];
                alu_car = diff[WIDTH];
                alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2:    alu_res = ~a;
            4'd3:    alu_res = a & b;
            4'd4:    alu_res = a | b;
            4'd5:    alu_res = a ^ b;
            4'd6:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd7:    alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
            4'd8:    alu_res = a << sh;
            4'd9:    alu_res = a >> sh;
            4'd10:   alu_res = $signed(a) >>> sh;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               is_mul;
    logic               mul_last;

    assign is_mul   = (op == 4'd11);
    assign mul_last = (state == MUL) && (cnt == CW'(WIDTH-1));
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_mul) state_next = MUL;
            MUL:     if (mul_last) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One multiplier bit per MUL cycle; the final partial sum goes straight to res.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (accept && is_mul) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (state == MUL) begin
            cnt    <= cnt + CW'(1);
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;
`endif

    // Result registers hold steady until the consumer takes them or a new result replaces them.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res       <= '0;
            car       <= 1'b0;
            of        <= 1'b0;
        end
`ifdef ALU_PIPE_MUL_EN
        else if (accept && is_mul) begin
            out_valid <= 1'b0;
        end else if (mul_last) begin
            out_valid <= 1'b1;
            res       <= acc_next[WIDTH-1:0];
            car       <= |acc_next[2*WIDTH-1:WIDTH];
            of        <= 1'b0;
        end
`endif
        else if (accept) begin
            out_valid <= 1'b1;
            res       <= alu_res;
            car       <= alu_car;
            of        <= alu_of;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign zf = (res == '0);
    assign nf = res[WIDTH-1];

endmodule
